// File: rtl/aes_round_engine.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_engine
//  Purpose  : Iterative AES round sequencer. Accepts one 128-bit block on a
//             valid/ready stream, applies one cipher round per clock using
//             round keys fetched from an external key store, and presents the
//             result on an output valid/ready stream. Encrypt or decrypt is
//             chosen per block.
//  Ports    : clk, rst_n (sync, active-low)
//             in_valid/in_ready/in_mode/in_data   - block input stream
//             rk_idx -> key store, rk_in <- key store (same-cycle return)
//             out_valid/out_ready/out_data        - result stream
//             busy, rnd_cnt                       - status
//  Config   : AES_DECRYPT_EN - when defined, the inverse datapath is compiled
//             in and in_mode is honoured; otherwise the engine is encrypt-only
//             and in_mode is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_round_engine #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [127:0]     in_data,
    output logic [IDX_W-1:0] rk_idx,
    input  logic [127:0]     rk_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy,
    output logic [IDX_W-1:0] rnd_cnt
);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ROUND = 2'd1;
    localparam logic [1:0] C_ST_DONE  = 2'd2;

    localparam logic [IDX_W-1:0] C_IDX_NR  = IDX_W'(NR);
    localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);

    // ------------------------------------------------------------------
    // GF(2^8) helpers. The S-box is computed as an inverse (x^254) plus
    // the affine map rather than a lookup table; it is purely combinational.
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte i sits at [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

`ifdef AES_DECRYPT_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return o;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       fsm_q, fsm_d;
    logic [IDX_W-1:0] rnd_cnt_q, rnd_cnt_d;
    logic             mode_q, mode_d;
    logic [127:0]     blk_q, blk_d;

    logic             w_mode_in;
    logic             w_last;
    logic [127:0]     w_enc;
    logic [127:0]     w_round;

    assign w_last = (rnd_cnt_q == C_IDX_NR);

    always_comb begin
        w_enc = shift_rows(sub_bytes(blk_q));
        if (!w_last) w_enc = mix_columns(w_enc);
        w_enc = w_enc ^ rk_in;
    end

`ifdef AES_DECRYPT_EN
    logic [127:0] w_dec;

    always_comb begin
        w_dec = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_in;
        if (!w_last) w_dec = inv_mix_columns(w_dec);
    end

    assign w_round   = mode_q ? w_dec : w_enc;
    assign w_mode_in = in_mode;
`else
    // Encrypt-only build: the mode input is kept on the port list but has
    // no effect, so every block runs the forward schedule.
    logic w_unused_mode;
    assign w_unused_mode = in_mode;
    assign w_round       = w_enc;
    assign w_mode_in     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d     = fsm_q;
        rnd_cnt_d = rnd_cnt_q;
        mode_d    = mode_q;
        blk_d     = blk_q;
        case (fsm_q)
            C_ST_IDLE: begin
                if (in_valid) begin
                    mode_d    = w_mode_in;
                    blk_d     = in_data ^ rk_in;   // initial AddRoundKey
                    rnd_cnt_d = C_IDX_ONE;
                    fsm_d     = C_ST_ROUND;
                end
            end
            C_ST_ROUND: begin
                blk_d = w_round;
                if (w_last) fsm_d = C_ST_DONE;
                else        rnd_cnt_d = rnd_cnt_q + C_IDX_ONE;
            end
            C_ST_DONE: begin
                if (out_ready) begin
                    fsm_d     = C_ST_IDLE;
                    rnd_cnt_d = '0;
                end
            end
            default: begin
                fsm_d     = C_ST_IDLE;
                rnd_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q     <= C_ST_IDLE;
            rnd_cnt_q <= '0;
            mode_q    <= 1'b0;
            blk_q     <= '0;
        end else begin
            fsm_q     <= fsm_d;
            rnd_cnt_q <= rnd_cnt_d;
            mode_q    <= mode_d;
            blk_q     <= blk_d;
        end
    end

    // Key index: in IDLE it follows the live mode input because the
    // accept-cycle AddRoundKey needs the key before mode is latched.
    always_comb begin
        rk_idx = '0;
        if (rst_n) begin
            case (fsm_q)
                C_ST_IDLE:  rk_idx = w_mode_in ? C_IDX_NR : '0;
                C_ST_ROUND: rk_idx = mode_q ? (C_IDX_NR - rnd_cnt_q) : rnd_cnt_q;
                default:    rk_idx = '0;
            endcase
        end
    end

    assign in_ready  = rst_n && (fsm_q == C_ST_IDLE);
    assign out_valid = (fsm_q == C_ST_DONE);
    assign busy      = (fsm_q == C_ST_ROUND) || (fsm_q == C_ST_DONE);
    assign out_data  = blk_q;
    assign rnd_cnt   = rnd_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_aes_round_engine
//  Purpose  : Scoreboard bench for aes_round_engine (NR=10). Round keys come
//             from a FIPS-197 expansion held in a bench-side key store.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_engine;

    localparam int NR    = 10;
    localparam int IDX_W = 4;
`ifdef AES_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    // Decrypt vector; in an encrypt-only build the mode bit is ignored, so
    // the same request must behave as encryption of the plaintext.
    localparam logic [127:0] DV_IN  = DEC_EN ? CT_B : PT_B;
    localparam logic [127:0] DV_EXP = DEC_EN ? PT_B : CT_B;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_mode = 1'b0;
    logic [127:0]     in_data = '0;
    logic             out_ready = 1'b1;
    logic             in_ready, out_valid, busy;
    logic [127:0]     rk_in, out_data;
    logic [IDX_W-1:0] rk_idx, rnd_cnt;

    always #5 clk = ~clk;

    aes_round_engine #(.NR(NR), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .rk_idx(rk_idx), .rk_in(rk_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .rnd_cnt(rnd_cnt)
    );

    // ---------------- key store ----------------
    logic [127:0] rka [0:NR];
    logic [127:0] rkb [0:NR];
    logic         key_sel = 1'b0;

    always_comb begin
        rk_in = '0;
        if (int'(rk_idx) <= NR) rk_in = key_sel ? rkb[int'(rk_idx)] : rka[int'(rk_idx)];
    end

    function automatic logic [7:0] tb_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = tb_xt(x);
        end
        return p;
    endfunction

    // Inverse by exhaustive search, then the FIPS-197 affine map.
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] v, y;
        v = 0;
        for (int j = 1; j < 256; j++) begin
            y = j[7:0];
            if (tb_mul(x, y) == 8'h01) v = y;
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] key, input bit which);
        logic [31:0] w [0:4*(NR+1)-1];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = tb_xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) begin
            if (which) rkb[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else       rka[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [127:0] exp_q [$];
    int           acc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event not seen as required (cycle %0d)", name, cyc);
    endtask

    // Monitor: latency on out_valid rise, data on handshake, hold stability.
    initial begin
        logic         prev_ov;
        logic [127:0] prev_d;
        prev_ov = 1'b0;
        prev_d  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (acc_q.size() == 0) flag_fail("unexpected_out_valid");
                    else check("latency", 128'(cyc - acc_q[0]), 128'(NR));
                end
                if (out_valid && prev_ov) check("out_data_hold", out_data, prev_d);
                if (out_valid) check("in_ready_while_done", {127'b0, in_ready}, 128'd0);
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    check("out_data", out_data, exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
                prev_ov = out_valid && !out_ready;
                prev_d  = out_data;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [127:0] data, input logic mode, input logic [127:0] exp,
                        input bit chk_rk, input bit hold, output int acc);
        logic em;
        em       = mode & DEC_EN;
        acc      = -1;
        in_valid = 1'b1;
        in_data  = data;
        in_mode  = mode;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (chk_rk) check("rk_idx_accept", 128'(rk_idx), em ? 128'(NR) : 128'd0);
                exp_q.push_back(exp);
                acc = cyc + 1;
                acc_q.push_back(acc);
                break;
            end
        end
        if (acc < 0) flag_fail("accept_timeout");
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        if (chk_rk && acc >= 0) begin
            for (int k = 1; k <= NR; k++) begin
                @(negedge clk);
                check("rk_idx_round", 128'(rk_idx), em ? 128'(NR - k) : 128'(k));
            end
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) flag_fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_inputs(input int n);
        for (int k = 0; k < n; k++) begin
            in_mode = ~in_mode;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  a1, a2, a3;
        bit  seen;
        expand(KEY_A, 1'b0);
        expand(KEY_B, 1'b1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready",  {127'b0, in_ready},  128'd0);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_busy",      {127'b0, busy},      128'd0);
        check("rst_rnd_cnt",   128'(rnd_cnt),       128'd0);
        check("rst_rk_idx",    128'(rk_idx),        128'd0);
        check("rst_out_data",  out_data,            128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {127'b0, in_ready}, 128'd1);
        @(posedge clk);
        #1;

        // FIPS-197 Appendix B vector
        key_sel = 1'b0;
        send(PT_A, 1'b0, CT_A, 1'b0, 1'b0, a1);
        wait_drain();

        // FIPS-197 C.1 encrypt, with the forward key schedule checked
        key_sel = 1'b1;
        send(PT_B, 1'b0, CT_B, 1'b1, 1'b0, a1);
        wait_drain();

        // C.1 decrypt, key schedule NR..0
        send(DV_IN, 1'b1, DV_EXP, 1'b1, 1'b0, a1);
        wait_drain();

        // Backpressure: hold out_ready low for 5 cycles of out_valid
        key_sel   = 1'b0;
        out_ready = 1'b0;
        send(PT_A, 1'b0, CT_A, 1'b0, 1'b0, a1);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag_fail("bp_out_valid_timeout");
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", {127'b0, out_valid}, 128'd1);
            check("bp_in_ready",  {127'b0, in_ready},  128'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_out_valid", {127'b0, out_valid}, 128'd0);
        check("bp_release_in_ready",  {127'b0, in_ready},  128'd1);
        out_ready = 1'b1;
        wait_drain();

        // Reset mid-operation at rnd_cnt == 5
        key_sel = 1'b1;
        send(PT_B, 1'b0, CT_B, 1'b0, 1'b0, a1);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rnd_cnt == 4'd5) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag_fail("abort_rnd5_timeout");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("abort_out_valid", {127'b0, out_valid}, 128'd0);
        check("abort_busy",      {127'b0, busy},      128'd0);
        check("abort_rnd_cnt",   128'(rnd_cnt),       128'd0);
        check("abort_in_ready",  {127'b0, in_ready},  128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            check("abort_stays_idle", {126'b0, busy, out_valid}, 128'd0);
        end
        @(posedge clk);
        #1;
        send(PT_B, 1'b0, CT_B, 1'b0, 1'b0, a1);
        wait_drain();

        // Back-to-back with in_valid held high
        send(PT_B, 1'b0, CT_B, 1'b0, 1'b1, a1);
        send(DV_IN, 1'b1, DV_EXP, 1'b0, 1'b1, a2);
        send(PT_B, 1'b0, CT_B, 1'b0, 1'b0, a3);
        check("b2b_spacing_1", 128'(a2 - a1), 128'(NR + 2));
        check("b2b_spacing_2", 128'(a3 - a2), 128'(NR + 2));
        wait_drain();

        // Mode and data wiggled after accept must not matter
        send(DV_IN, 1'b1, DV_EXP, 1'b0, 1'b0, a1);
        toggle_inputs(12);
        wait_drain();
        send(PT_B, 1'b0, CT_B, 1'b0, 1'b0, a1);
        toggle_inputs(12);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
